// File: rtl/mux_tree_pipe_if.sv
// Handshake bundle for mux_tree_pipe: upstream beat (data/sel) and downstream result.
// valid/ready: a beat moves when valid && ready are both high at a rising edge; a producer
// holds its payload stable while valid && !ready, and ready never depends on the same side's valid.
interface mux_tree_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 32
);
    localparam int SEL_W = $clog2(N_IN);

    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;

    // master: the environment around the block; slave: the block itself
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// N_IN-to-1 binary mux tree with a register stage every LPS tree levels and an
// elastic valid/ready pipeline; selects >= N_IN yield zero data with the err flag.
module mux_tree_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 32,
    parameter int LPS   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_tree_pipe_if.slave   bus
);
    localparam int LVL    = $clog2(N_IN);
    localparam int SEL_W  = LVL;
    localparam int STAGES = (LVL + LPS - 1) / LPS;
    localparam logic [SEL_W:0] N_IN_EXT = N_IN[SEL_W:0];

    typedef logic [WIDTH-1:0] vec_t [N_IN];

    // Node count entering tree level l; odd leftovers survive into the next level.
    function automatic int cnt_at(input int l);
        int n;
        n = N_IN;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Apply tree levels lo..hi-1 in place; node j of a level lands in slot j.
    function automatic vec_t eval_levels(input vec_t d, input logic [SEL_W-1:0] s,
                                         input int lo, input int hi);
        vec_t t;
        int   n;
        t = d;
        for (int l = 0; l < LVL; l++) begin
            n = cnt_at(l);
            if (l >= lo && l < hi) begin
                for (int j = 0; j < N_IN; j++) begin
                    if (2*j + 1 < n)  t[j] = s[l] ? t[2*j + 1] : t[2*j];
                    else if (2*j < n) t[j] = t[2*j];
                    else              t[j] = '0;
                end
            end
        end
        return t;
    endfunction

    vec_t              r_data [STAGES];
    logic [SEL_W-1:0]  r_sel  [STAGES];
    logic [STAGES-1:0] r_err;
    logic [STAGES-1:0] r_valid;

    logic [STAGES:0]   w_en;
    logic              w_err_in;
    vec_t              w_leaf;
    vec_t              w_nxt  [STAGES];

    // Ready ripples back from the output; a stage may load when empty or when it drains.
    always_comb begin
        w_en[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_en[k] = !r_valid[k] || w_en[k+1];
        end
    end

    always_comb begin
        w_err_in = ({1'b0, bus.in_sel} >= N_IN_EXT);
        for (int j = 0; j < N_IN; j++) begin
            w_leaf[j] = w_err_in ? '0 : bus.in_data[j*WIDTH +: WIDTH];
        end
        w_nxt[0] = eval_levels(w_leaf, bus.in_sel, 0, LPS);
        for (int k = 1; k < STAGES; k++) begin
            w_nxt[k] = eval_levels(r_data[k-1], r_sel[k-1], k*LPS, (k+1)*LPS);
        end
    end

    // Payload registers only load behind a valid beat, so stalls and bubbles keep them stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sel[k] <= '0;
                for (int j = 0; j < N_IN; j++) r_data[k][j] <= '0;
            end
        end else begin
            if (w_en[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_data[0] <= w_nxt[0];
                    r_sel[0]  <= bus.in_sel;
                    r_err[0]  <= w_err_in;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_en[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= w_nxt[k];
                        r_sel[k]  <= r_sel[k-1];
                        r_err[k]  <= r_err[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = w_en[0];
    assign bus.out_data  = r_data[STAGES-1][0];
    assign bus.out_err   = r_err[STAGES-1];
    assign bus.out_valid = r_valid[STAGES-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Three configurations of mux_tree_pipe driven with directed and random beats;
// results are checked against a plain index-and-range reference model.
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    localparam int NIN [3] = '{32, 5, 2};
    localparam int ST  [3] = '{3, 2, 1};
    localparam int SMX [3] = '{31, 7, 1};

    mux_tree_pipe_if #(.WIDTH(32), .N_IN(32)) if_a ();
    mux_tree_pipe_if #(.WIDTH(8),  .N_IN(5))  if_b ();
    mux_tree_pipe_if #(.WIDTH(1),  .N_IN(2))  if_c ();

    mux_tree_pipe #(.WIDTH(32), .N_IN(32), .LPS(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    mux_tree_pipe #(.WIDTH(8),  .N_IN(5),  .LPS(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    mux_tree_pipe #(.WIDTH(1),  .N_IN(2),  .LPS(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          acc;
    } exp_t;

    exp_t exp_q_a[$];
    exp_t exp_q_b[$];
    exp_t exp_q_c[$];

    logic [31:0] mem_a [32];
    logic [7:0]  mem_b [5];
    logic        mem_c [2];

    always_comb begin
        for (int i = 0; i < 32; i++) if_a.in_data[i*32 +: 32] = mem_a[i];
        for (int i = 0; i < 5; i++)  if_b.in_data[i*8 +: 8]   = mem_b[i];
        if_c.in_data = {mem_c[1], mem_c[0]};
    end

    bit   chk_lat  = 1'b0;
    bit   scramble = 1'b1;
    int   rmode    = 0;
    bit   pv [3];
    bit   pr [3];
    logic [31:0] pd [3];
    logic pe [3];

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input int id, input int sel);
        exp_t x;
        x.acc = 0;
        x.e   = (sel >= NIN[id]);
        x.d   = '0;
        if (!x.e) begin
            case (id)
                0:       x.d = mem_a[sel];
                1:       x.d = {24'h0, mem_b[sel]};
                default: x.d = {31'h0, mem_c[sel]};
            endcase
        end
        return x;
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return exp_q_a.size();
            1:       return exp_q_b.size();
            default: return exp_q_c.size();
        endcase
    endfunction

    task automatic push(input int id, input exp_t x);
        case (id)
            0:       exp_q_a.push_back(x);
            1:       exp_q_b.push_back(x);
            default: exp_q_c.push_back(x);
        endcase
    endtask

    task automatic pop(input int id, output exp_t x);
        case (id)
            0:       x = exp_q_a.pop_front();
            1:       x = exp_q_b.pop_front();
            default: x = exp_q_c.pop_front();
        endcase
    endtask

    function automatic bit get_ready(input int id);
        case (id)
            0:       return if_a.in_ready;
            1:       return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    task automatic set_in(input int id, input bit v, input int sel);
        case (id)
            0: begin if_a.in_valid = v; if_a.in_sel = sel[4:0]; end
            1: begin if_b.in_valid = v; if_b.in_sel = sel[2:0]; end
            default: begin if_c.in_valid = v; if_c.in_sel = sel[0:0]; end
        endcase
    endtask

    task automatic scramble_data(input int id);
        case (id)
            0:       for (int i = 0; i < 32; i++) mem_a[i] = $urandom;
            1:       for (int i = 0; i < 5; i++)  mem_b[i] = 8'($urandom);
            default: for (int i = 0; i < 2; i++)  mem_c[i] = 1'($urandom);
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int id, input int sel);
        int   budget;
        bit   ok;
        exp_t x;
        budget = 0;
        ok     = 1'b0;
        set_in(id, 1'b1, sel);
        while (!ok && budget < 200) begin
            @(negedge clk);
            if (get_ready(id)) begin
                x     = model(id, sel);
                x.acc = cyc + 1;
                push(id, x);
                ok    = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
        end
        check("send_accepted", {31'h0, ok}, 32'h1);
        set_in(id, 1'b0, int'($urandom));
        if (scramble) scramble_data(id);
    endtask

    task automatic wait_drain(input int id);
        int b;
        b = 0;
        while (qsize(id) != 0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        check("drain_empty", qsize(id), 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int id, input logic v, input logic r, input logic [31:0] d, input logic e);
        exp_t x;
        if (pv[id] && !pr[id]) begin
            check("stall_valid", {31'h0, v}, 32'h1);
            check("stall_data", d, pd[id]);
            check("stall_err", {31'h0, e}, {31'h0, pe[id]});
        end
        pv[id] = v; pr[id] = r; pd[id] = d; pe[id] = e;
        if (v && r) begin
            if (qsize(id) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat dut=%0d: got data %h err %0b with no beat outstanding", id, d, e);
            end else begin
                pop(id, x);
                check("out_data", d, x.d);
                check("out_err", {31'h0, e}, {31'h0, x.e});
                if (chk_lat) check("latency_edge", cyc, x.acc + ST[id] - 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if_a.out_valid, if_a.out_ready, if_a.out_data, if_a.out_err);
            mon(1, if_b.out_valid, if_b.out_ready, 32'(if_b.out_data), if_b.out_err);
            mon(2, if_c.out_valid, if_c.out_ready, 32'(if_c.out_data), if_c.out_err);
        end else begin
            for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic r;
        #1;
        case (rmode)
            0:       r = 1'b1;
            1:       r = 1'b0;
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        if_a.out_ready = r;
        if_b.out_ready = r;
        if_c.out_ready = r;
    end

    task automatic random_run(input int id, input int beats);
        for (int n = 0; n < beats; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_in(id, 1'b0, int'($urandom));
                @(posedge clk); #1;
            end
            send(id, int'($urandom_range(0, SMX[id])));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        int acc_cnt;
        exp_t x;
        rst_n = 1'b0;
        for (int id = 0; id < 3; id++) set_in(id, 1'b0, 0);
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b1; if_c.out_ready = 1'b1;
        for (int id = 0; id < 3; id++) scramble_data(id);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_a", {31'h0, if_a.out_valid}, 32'h0);
        check("rst_data_a", if_a.out_data, 32'h0);
        check("rst_err_a", {31'h0, if_a.out_err}, 32'h0);
        check("rst_valid_b", {31'h0, if_b.out_valid}, 32'h0);
        check("rst_data_b", 32'(if_b.out_data), 32'h0);
        check("rst_valid_c", {31'h0, if_c.out_valid}, 32'h0);
        check("rst_data_c", 32'(if_c.out_data), 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sweep on the 32-input tree, back to back
        scramble = 1'b0;
        for (int i = 0; i < 32; i++) mem_a[i] = 32'hA000_0000 + 32'(i);
        chk_lat = 1'b1;
        c0 = cyc;
        for (int s = 0; s < 32; s++) send(0, s);
        check("sweep_one_per_cycle", cyc - c0, 32'd32);
        wait_drain(0);

        // Non-power-of-two tree: in-range and out-of-range selects
        scramble = 1'b1;
        send(1, 4); send(1, 5); send(1, 7); send(1, 3);
        wait_drain(1);
        send(2, 0); send(2, 1);
        wait_drain(2);
        chk_lat = 1'b0;

        // Backpressure: continuous valid into a stopped output
        scramble = 1'b0;
        rmode = 1;
        @(posedge clk); #2;
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1'b1, int'($urandom_range(0, 31)));
            @(negedge clk);
            if (if_a.in_ready) begin
                x     = model(0, int'(if_a.in_sel));
                x.acc = cyc + 1;
                push(0, x);
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", acc_cnt, 32'(ST[0]));
        @(negedge clk);
        check("bp_in_ready_low", {31'h0, if_a.in_ready}, 32'h0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 0);
        rmode = 0;
        wait_drain(0);

        // Asynchronous reset with three beats in flight
        rmode = 1;
        @(posedge clk); #2;
        send(0, 3); send(0, 9); send(0, 20);
        check("pre_rst_valid", {31'h0, if_a.out_valid}, 32'h1);
        check("pre_rst_data", if_a.out_data, exp_q_a[0].d);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, if_a.out_valid}, 32'h0);
        check("async_rst_data", if_a.out_data, 32'h0);
        check("async_rst_err", {31'h0, if_a.out_err}, 32'h0);
        exp_q_a.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        rmode = 0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_idle", {31'h0, if_a.out_valid}, 32'h0);

        // Random valid/ready on all three configurations at once
        scramble = 1'b1;
        rmode = 2;
        fork
            random_run(0, 60);
            random_run(1, 60);
            random_run(2, 60);
        join
        rmode = 0;
        wait_drain(0);
        wait_drain(1);
        wait_drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
